// File: rtl/video_pkg.sv
// Shared definitions for the video lock qualifier: lock FSM states,
// default resolution constants and counter width helpers.
package video_pkg;

  localparam int DEFAULT_H_WIDTH     = 1920;
  localparam int DEFAULT_V_HEIGHT    = 1080;
  localparam int DEFAULT_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    UNLOCKED,
    CHECK,
    WRITE,
    RUN
  } lock_state_e;

  // Width of a counter that must hold 0..limit+1 (one overflow code above the target).
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 2);
  endfunction

endpackage

// File: rtl/video_measure.sv
// Frame timing measurement: vs/de edge detection, saturating pixel and line
// counters, sticky bad-frame flag and the partial-first-frame flag.
// With VIDEO_LOCK_STATS_EN defined, the raw line/frame measurements are exported.
module video_measure
  import video_pkg::*;
#(
  parameter int H_WIDTH  = DEFAULT_H_WIDTH,
  parameter int V_HEIGHT = DEFAULT_V_HEIGHT,
  localparam int HW = cnt_width(H_WIDTH),
  localparam int VW = cnt_width(V_HEIGHT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vs_i,
  input  logic          de_i,
  output logic          vs_rise,
  output logic          frame_good
`ifdef VIDEO_LOCK_STATS_EN
  ,
  output logic          stat_line_end,
  output logic [HW-1:0] stat_line_len,
  output logic [VW-1:0] stat_frame_lines
`endif
);

  localparam logic [HW-1:0] H_FULL = HW'(H_WIDTH);
  localparam logic [HW-1:0] H_OVER = HW'(H_WIDTH + 1);
  localparam logic [VW-1:0] V_FULL = VW'(V_HEIGHT);
  localparam logic [VW-1:0] V_OVER = VW'(V_HEIGHT + 1);

  logic          vs_r;
  logic          de_r;
  logic          first_r;
  logic          frame_bad;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_next;
  logic [VW-1:0] vcnt;
  logic [VW-1:0] vcnt_close;
  logic          de_rise;
  logic          line_end;
  logic          line_good;
  logic          line_bad;

  assign vs_rise   = vs_i & ~vs_r;
  assign de_rise   = de_i & ~de_r;
  assign line_end  = de_r & ~de_i;
  assign line_good = line_end & (hcnt == H_FULL);
  assign line_bad  = line_end & ~line_good;

  // Next pixel count inside a frame: restart on a new line, saturate one above the target.
  always_comb begin
    hcnt_next = hcnt;
    if (de_rise) begin
      hcnt_next = HW'(1);
    end else if (de_i && (hcnt != H_OVER)) begin
      hcnt_next = hcnt + HW'(1);
    end
  end

  // Line count including a good line that ends in this very cycle, saturating.
  always_comb begin
    vcnt_close = vcnt;
    if (line_good && (vcnt != V_OVER)) begin
      vcnt_close = vcnt + VW'(1);
    end
  end

  assign frame_good = ~first_r & ~frame_bad & ~line_bad & ~de_i & (vcnt_close == V_FULL);

`ifdef VIDEO_LOCK_STATS_EN
  assign stat_line_end    = line_end;
  assign stat_line_len    = hcnt;
  assign stat_frame_lines = vcnt_close;
`endif

  // Edge history and per-frame counters; everything restarts at each frame boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_r      <= 1'b0;
      de_r      <= 1'b0;
      first_r   <= 1'b1;
      frame_bad <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
    end else begin
      vs_r <= vs_i;
      de_r <= de_i;
      if (vs_rise) begin
        first_r   <= 1'b0;
        frame_bad <= 1'b0;
        vcnt      <= '0;
        hcnt      <= de_i ? HW'(1) : '0;
      end else begin
        hcnt      <= hcnt_next;
        vcnt      <= vcnt_close;
        frame_bad <= frame_bad | line_bad | (hcnt_next == H_OVER);
      end
    end
  end

endmodule

// File: rtl/video_lock.sv
// Frame-timing qualifier in front of the DDR frame delayer. Enables writing
// after LOCK_FRAMES consecutive good frames and reading one frame later;
// any bad frame drops both enables at the next frame boundary.
// Optional feature macro: VIDEO_LOCK_STATS_EN adds meas_h_o, meas_v_o, drops_o.
module video_lock
  import video_pkg::*;
#(
  parameter int H_WIDTH     = DEFAULT_H_WIDTH,
  parameter int V_HEIGHT    = DEFAULT_V_HEIGHT,
  parameter int LOCK_FRAMES = DEFAULT_LOCK_FRAMES,
  localparam int HW = cnt_width(H_WIDTH),
  localparam int VW = cnt_width(V_HEIGHT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vs_i,
  input  logic          de_i,
  output logic          wen_o,
  output logic          ren_o,
  output logic          locked_o,
  output logic          bad_o
`ifdef VIDEO_LOCK_STATS_EN
  ,
  output logic [HW-1:0] meas_h_o,
  output logic [VW-1:0] meas_v_o,
  output logic [7:0]    drops_o
`endif
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES);

  lock_state_e state;
  lock_state_e state_next;
  logic [3:0]  good_cnt;
  logic [3:0]  good_cnt_next;
  logic        vs_rise;
  logic        frame_good;

`ifdef VIDEO_LOCK_STATS_EN
  logic          stat_line_end;
  logic [HW-1:0] stat_line_len;
  logic [VW-1:0] stat_frame_lines;
`endif

  video_measure #(
    .H_WIDTH  (H_WIDTH),
    .V_HEIGHT (V_HEIGHT)
  ) u_measure (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .vs_i             (vs_i),
    .de_i             (de_i),
    .vs_rise          (vs_rise),
    .frame_good       (frame_good)
`ifdef VIDEO_LOCK_STATS_EN
    ,
    .stat_line_end    (stat_line_end),
    .stat_line_len    (stat_line_len),
    .stat_frame_lines (stat_frame_lines)
`endif
  );

  // Lock decision, taken only when a frame closes.
  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    if (vs_rise) begin
      if (!frame_good) begin
        state_next    = UNLOCKED;
        good_cnt_next = '0;
      end else begin
        case (state)
          UNLOCKED: begin
            good_cnt_next = 4'd1;
            state_next    = (LOCK_FRAMES == 1) ? WRITE : CHECK;
          end
          CHECK: begin
            good_cnt_next = good_cnt + 4'd1;
            if ((good_cnt + 4'd1) == LOCK_TARGET) begin
              state_next = WRITE;
            end
          end
          WRITE:   state_next = RUN;
          RUN:     state_next = RUN;
          default: state_next = UNLOCKED;
        endcase
      end
    end
  end

  // State and registered enables; they can only move on the cycle after a frame boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
      wen_o    <= 1'b0;
      ren_o    <= 1'b0;
      bad_o    <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
      wen_o    <= (state_next == WRITE) || (state_next == RUN);
      ren_o    <= (state_next == RUN);
      bad_o    <= vs_rise & ~frame_good;
    end
  end

  assign locked_o = wen_o;

`ifdef VIDEO_LOCK_STATS_EN
  // Last line length, last frame's good-line count and a saturating count of lock losses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meas_h_o <= '0;
      meas_v_o <= '0;
      drops_o  <= '0;
    end else begin
      if (stat_line_end) begin
        meas_h_o <= stat_line_len;
      end
      if (vs_rise) begin
        meas_v_o <= stat_frame_lines;
      end
      if (vs_rise && !frame_good && ((state == WRITE) || (state == RUN)) && (drops_o != 8'hFF)) begin
        drops_o <= drops_o + 8'd1;
      end
    end
  end
`endif

endmodule
